// File: rtl/apb_master_pkg.sv
// Shared types and default widths for the APB initiator and the APB slaves of this subsystem.
package apb_master_pkg;

  localparam int APB_ADDR_W      = 12;
  localparam int APB_DATA_W      = 32;
  localparam int APB_TIMEOUT_CYC = 256;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } apb_state_e;

endpackage

// File: rtl/apb_master_if.sv
// Command/response side plus APB side of the initiator, bundled with master (initiator) and
// slave (requester + APB fabric) views.
interface apb_master_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
);
  // Handshakes: a beat moves on a rising clk edge where valid && ready are both 1; the sender
  // holds valid and its payload stable until that edge, and ready may depend on state only.
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              psel;
  logic              penable;
  logic [ADDR_W-1:0] paddr;
  logic              pwrite;
  logic [DATA_W-1:0] pwdata;
  logic [DATA_W-1:0] prdata;
  logic              pready;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, prdata, pready,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err, psel, penable, paddr, pwrite, pwdata
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, prdata, pready,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, psel, penable, paddr, pwrite, pwdata
  );

endinterface

// File: rtl/apb_timeout_cnt.sv
// ACCESS-phase wait-state counter; expired flags the wait cycle that would reach LIMIT.
module apb_timeout_cnt #(
  parameter int LIMIT = 256,
  parameter int CW    = $clog2(LIMIT + 1)
) (
  input  logic clk,
  input  logic rstn,
  input  logic clr,
  input  logic inc,
  output logic expired
);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != CW'(LIMIT))) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // The LIMIT-th consecutive wait cycle is the one where the pre-increment count is LIMIT-1.
  assign expired = inc && (cnt_q == CW'(LIMIT - 1));

endmodule

// File: rtl/apb_master.sv
// APB initiator: one command at a time through IDLE -> SETUP -> ACCESS -> RESP.
// Define APB_MST_TIMEOUT_EN to abort ACCESS after TIMEOUT_CYC wait states with rsp_err=1.
module apb_master
  import apb_master_pkg::*;
#(
  parameter int ADDR_W      = APB_ADDR_W,
  parameter int DATA_W      = APB_DATA_W,
  parameter int TIMEOUT_CYC = APB_TIMEOUT_CYC
) (
  input  logic       clk,
  input  logic       rstn,
  apb_master_if.master bus,
  output apb_state_e state_o
);

  apb_state_e        state_q,     state_d;
  logic              psel_q,      psel_d;
  logic              penable_q,   penable_d;
  logic [ADDR_W-1:0] paddr_q,     paddr_d;
  logic              pwrite_q,    pwrite_d;
  logic [DATA_W-1:0] pwdata_q,    pwdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q,   rsp_err_d;
  logic              timeout_hit;

`ifdef APB_MST_TIMEOUT_EN
  apb_timeout_cnt #(
    .LIMIT (TIMEOUT_CYC)
  ) u_timeout_cnt (
    .clk     (clk),
    .rstn    (rstn),
    .clr     (state_q == ST_SETUP),
    .inc     ((state_q == ST_ACCESS) && !bus.pready),
    .expired (timeout_hit)
  );
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    paddr_d     = paddr_q;
    pwrite_d    = pwrite_q;
    pwdata_d    = pwdata_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.cmd_valid) begin
          paddr_d   = bus.cmd_addr;
          pwrite_d  = bus.cmd_write;
          pwdata_d  = bus.cmd_wdata;
          psel_d    = 1'b1;
          penable_d = 1'b0;
          state_d   = ST_SETUP;
        end
      end
      ST_SETUP: begin
        penable_d = 1'b1;
        state_d   = ST_ACCESS;
      end
      ST_ACCESS: begin
        // A slave completing on the expiry cycle wins over the abort.
        if (bus.pready) begin
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_rdata_d = pwrite_q ? '0 : bus.prdata;
          rsp_err_d   = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = ST_RESP;
        end else if (timeout_hit) begin
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b1;
          rsp_valid_d = 1'b1;
          state_d     = ST_RESP;
        end
      end
      ST_RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= ST_IDLE;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      paddr_q     <= '0;
      pwrite_q    <= 1'b0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      paddr_q     <= paddr_d;
      pwrite_q    <= pwrite_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign bus.cmd_ready = (state_q == ST_IDLE);
  assign bus.psel      = psel_q;
  assign bus.penable   = penable_q;
  assign bus.paddr     = paddr_q;
  assign bus.pwrite    = pwrite_q;
  assign bus.pwdata    = pwdata_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
`ifdef APB_MST_TIMEOUT_EN
  assign bus.rsp_err   = rsp_err_q;
`else
  assign bus.rsp_err   = 1'b0;
`endif
  assign state_o       = state_q;

endmodule

// File: tb/tb_apb_master.sv
// Directed bench for apb_master against a small SRAM-style APB slave model with wait states.
module tb_apb_master;
  import apb_master_pkg::*;

  logic       clk = 1'b0;
  logic       rstn;
  apb_state_e state;

  apb_master_if #(.ADDR_W(12), .DATA_W(32)) bus ();

  apb_master #(
    .ADDR_W      (12),
    .DATA_W      (32),
    .TIMEOUT_CYC (8)
  ) dut (
    .clk     (clk),
    .rstn    (rstn),
    .bus     (bus),
    .state_o (state)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Slave: 256-word SRAM, read-only ID word 0x12345678 at 0x024, wait_cfg wait states per access.
  logic [31:0] mem [0:255];
  int   wait_cfg = 0;
  int   wait_cnt = 0;
  logic stuck    = 1'b0;

  always_comb begin
    bus.pready = bus.psel && bus.penable && !stuck && (wait_cnt >= wait_cfg);
    if (bus.pwrite)
      bus.prdata = 32'h0;
    else if (bus.paddr == 12'h024)
      bus.prdata = 32'h1234_5678;
    else
      bus.prdata = mem[bus.paddr[9:2]];
  end

  always @(posedge clk) begin
    if (bus.psel && bus.penable) begin
      if (bus.pready) begin
        wait_cnt <= 0;
        if (bus.pwrite) mem[bus.paddr[9:2]] <= bus.pwdata;
      end else begin
        wait_cnt <= wait_cnt + 1;
      end
    end else begin
      wait_cnt <= 0;
    end
  end

  // Monitor: phase cycle totals and payload stability during ACCESS.
  int          setup_tot = 0;
  int          access_tot = 0;
  int          unstable_tot = 0;
  logic        prev_en = 1'b0;
  logic [11:0] acc_addr = '0;
  logic        acc_write = 1'b0;
  logic [31:0] acc_wdata = '0;

  always @(negedge clk) begin
    if (bus.psel && !bus.penable) setup_tot <= setup_tot + 1;
    if (bus.psel && bus.penable) begin
      access_tot <= access_tot + 1;
      if (!prev_en) begin
        acc_addr  <= bus.paddr;
        acc_write <= bus.pwrite;
        acc_wdata <= bus.pwdata;
      end else if (bus.paddr != acc_addr || bus.pwrite != acc_write || bus.pwdata != acc_wdata) begin
        unstable_tot <= unstable_tot + 1;
      end
    end
    prev_en <= bus.psel && bus.penable;
  end

  task automatic send_cmd(input logic w, input logic [11:0] a, input logic [31:0] d);
    int t = 0;
    @(negedge clk);
    while (!bus.cmd_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("cmd_ready_wait", {31'b0, bus.cmd_ready}, 32'd1);
    bus.cmd_write = w;
    bus.cmd_addr  = a;
    bus.cmd_wdata = d;
    bus.cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
  endtask

  // lat = rising edges after the accept edge until rsp_valid is seen.
  task automatic wait_rsp(output int lat, output logic [31:0] rd, output logic err, output int busy_ready);
    lat = 0;
    busy_ready = 0;
    @(negedge clk);
    while (!bus.rsp_valid && lat < 300) begin
      if (bus.cmd_ready) busy_ready++;
      @(negedge clk);
      lat++;
    end
    check("rsp_valid_seen", {31'b0, bus.rsp_valid}, 32'd1);
    rd  = bus.rsp_rdata;
    err = bus.rsp_err;
  endtask

  task automatic consume(input int hold);
    logic [31:0] rd0;
    logic [11:0] pa0;
    rd0 = bus.rsp_rdata;
    pa0 = bus.paddr;
    for (int i = 0; i < hold; i++) begin
      if (i == 2) begin
        bus.cmd_addr  = 12'h3FC;
        bus.cmd_valid = 1'b1;
      end
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      check("hold_valid", {31'b0, bus.rsp_valid}, 32'd1);
      check("hold_rdata", bus.rsp_rdata, rd0);
      check("hold_psel", {31'b0, bus.psel}, 32'd0);
      check("hold_cmd_ready", {31'b0, bus.cmd_ready}, 32'd0);
      check("hold_state", {30'b0, state}, {30'b0, ST_RESP});
      check("hold_paddr", {20'b0, bus.paddr}, {20'b0, pa0});
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b0;
    @(negedge clk);
    check("rsp_cleared", {31'b0, bus.rsp_valid}, 32'd0);
    check("ready_after_rsp", {31'b0, bus.cmd_ready}, 32'd1);
  endtask

  task automatic run_xfer(input logic w, input logic [11:0] a, input logic [31:0] d,
                          input logic [31:0] exp_rd, input int exp_lat, input logic exp_err,
                          input int hold);
    int          s0, a0, u0, lat, br;
    logic [31:0] rd;
    logic        err;
    s0 = setup_tot;
    a0 = access_tot;
    u0 = unstable_tot;
    exp_q.push_back(exp_rd);
    send_cmd(w, a, d);
    wait_rsp(lat, rd, err, br);
    check("latency", lat, exp_lat);
    check("rsp_rdata", rd, exp_q.pop_front());
    check("rsp_err", {31'b0, err}, {31'b0, exp_err});
    check("cmd_ready_busy", br, 0);
    consume(hold);
    check("setup_cycles", setup_tot - s0, 1);
    check("access_cycles", access_tot - a0, exp_lat - 1);
    check("access_stable", unstable_tot - u0, 0);
    check("acc_paddr", {20'b0, acc_addr}, {20'b0, a});
    check("acc_pwrite", {31'b0, acc_write}, {31'b0, w});
    check("acc_pwdata", acc_wdata, d);
  endtask

  initial begin
    int seen;
    rstn          = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_wdata = '0;
    bus.rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_cmd_ready", {31'b0, bus.cmd_ready}, 32'd1);
    check("rst_rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
    check("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
    check("rst_rsp_err", {31'b0, bus.rsp_err}, 32'd0);
    check("rst_psel", {31'b0, bus.psel}, 32'd0);
    check("rst_penable", {31'b0, bus.penable}, 32'd0);
    check("rst_paddr", {20'b0, bus.paddr}, 32'd0);
    check("rst_pwrite", {31'b0, bus.pwrite}, 32'd0);
    check("rst_pwdata", bus.pwdata, 32'd0);
    check("rst_state", {30'b0, state}, {30'b0, ST_IDLE});
    rstn = 1'b1;

    // Zero-wait write, then a read with 3 wait states.
    wait_cfg = 0;
    run_xfer(1'b1, 12'h010, 32'hDEAD_BEEF, 32'h0, 2, 1'b0, 0);
    wait_cfg = 3;
    run_xfer(1'b0, 12'h024, 32'h0, 32'h1234_5678, 5, 1'b0, 0);

    // Write then read back through the SRAM.
    wait_cfg = 0;
    run_xfer(1'b1, 12'h100, 32'hA5A5_A5A5, 32'h0, 2, 1'b0, 0);
    run_xfer(1'b0, 12'h100, 32'h0, 32'hA5A5_A5A5, 2, 1'b0, 0);

    // Response backpressure for 5 cycles with a stray command pulse.
    run_xfer(1'b0, 12'h010, 32'h0, 32'hDEAD_BEEF, 2, 1'b0, 5);

`ifdef APB_MST_TIMEOUT_EN
    stuck = 1'b1;
    run_xfer(1'b0, 12'h024, 32'h0, 32'h0, 9, 1'b1, 0);
    stuck    = 1'b0;
    wait_cfg = 7;
    run_xfer(1'b0, 12'h024, 32'h0, 32'h1234_5678, 9, 1'b0, 0);
    wait_cfg = 0;
`endif

    // Reset in the second ACCESS cycle.
    wait_cfg = 5;
    send_cmd(1'b0, 12'h100, 32'h0);
    @(posedge clk);
    @(posedge clk);
    #1;
    check("pre_rst_penable", {31'b0, bus.penable}, 32'd1);
    #1;
    rstn = 1'b0;
    #1;
    check("rst_async_psel", {31'b0, bus.psel}, 32'd0);
    check("rst_async_penable", {31'b0, bus.penable}, 32'd0);
    check("rst_async_rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    check("rst_release_cmd_ready", {31'b0, bus.cmd_ready}, 32'd1);
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.rsp_valid || bus.psel) seen++;
    end
    check("no_rsp_after_rst", seen, 0);
    wait_cfg = 0;
    run_xfer(1'b1, 12'h040, 32'h0BAD_F00D, 32'h0, 2, 1'b0, 0);
    run_xfer(1'b0, 12'h040, 32'h0, 32'h0BAD_F00D, 2, 1'b0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1);
  end

endmodule
